// File: rtl/vga_board_renderer_pkg.sv
// ============================================================================
// vga_board_renderer_pkg : board geometry, colour constants, pixel classifier
// Revision 1.0
// ============================================================================
`default_nettype none

package vga_board_renderer_pkg;

  localparam int H_ACT0    = 144;
  localparam int V_ACT0    = 35;
  localparam int TILE      = 100;
  localparam int GAP       = 8;

  localparam logic signed [10:0] BOARD_X0  = 11'(H_ACT0 + 100);
  localparam logic signed [10:0] BOARD_Y0  = 11'(V_ACT0 + 20);
  localparam logic signed [10:0] BOARD_LEN = 11'(4 * TILE + 5 * GAP);
  localparam logic signed [10:0] TILE_LEN  = 11'(TILE);
  localparam logic [9:0]         SNAP_LINE = 10'd520;
  localparam logic [5:0]         FLASH_FRM = 6'd32;

  localparam logic [11:0] BG      = 12'h123;
  localparam logic [11:0] WIN_BG  = 12'h0A0;
  localparam logic [11:0] LOSE_BG = 12'hA00;
  localparam logic [11:0] GRID_C  = 12'h876;
  localparam logic [11:0] EMPTY_C = 12'hCBA;
  localparam logic [11:0] FLASH_C = 12'hFFF;
  localparam logic [11:0] TILE_C1  = 12'hEED;
  localparam logic [11:0] TILE_C2  = 12'hEEC;
  localparam logic [11:0] TILE_C3  = 12'hFB7;
  localparam logic [11:0] TILE_C4  = 12'hF96;
  localparam logic [11:0] TILE_C5  = 12'hF75;
  localparam logic [11:0] TILE_C6  = 12'hF53;
  localparam logic [11:0] TILE_C7  = 12'hEC7;
  localparam logic [11:0] TILE_C8  = 12'hEC6;
  localparam logic [11:0] TILE_C9  = 12'hEC5;
  localparam logic [11:0] TILE_C10 = 12'hEC3;
  localparam logic [11:0] TILE_C11 = 12'hEC2;

  typedef enum logic [1:0] {
    PIX_OUTSIDE = 2'd0,
    PIX_GRID    = 2'd1,
    PIX_TILE    = 2'd2
  } pix_class_e;

  typedef struct packed {
    logic       outside;
    logic       on_tile;
    logic [1:0] idx;
  } axis_pos_t;

  // Position along one axis of the board; tile k spans [GAP+k*(TILE+GAP), +TILE).
  function automatic axis_pos_t locate_axis(input logic signed [10:0] r);
    axis_pos_t         p;
    logic signed [10:0] start;
    p.outside = (r < 11'sd0) || (r >= BOARD_LEN);
    p.on_tile = 1'b0;
    p.idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      start = 11'(GAP + k * (TILE + GAP));
      if (!p.outside && (r >= start) && (r < start + TILE_LEN)) begin
        p.on_tile = 1'b1;
        p.idx     = 2'(k);
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_board_renderer_tile_color_lut.sv
// ============================================================================
// tile_color_lut : 4-bit tile exponent to 12-bit colour, saturating above 11
// Revision 1.0
// ============================================================================
`default_nettype none

module tile_color_lut
  import vga_board_renderer_pkg::*;
(
  input  logic [3:0]  tile_exp,
  output logic [11:0] color
);

  always_comb begin
    color = TILE_C11;
    case (tile_exp)
      4'd0:    color = EMPTY_C;
      4'd1:    color = TILE_C1;
      4'd2:    color = TILE_C2;
      4'd3:    color = TILE_C3;
      4'd4:    color = TILE_C4;
      4'd5:    color = TILE_C5;
      4'd6:    color = TILE_C6;
      4'd7:    color = TILE_C7;
      4'd8:    color = TILE_C8;
      4'd9:    color = TILE_C9;
      4'd10:   color = TILE_C10;
      default: color = TILE_C11;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vga_board_renderer.sv
// ============================================================================
// vga_board_renderer : 4x4 board to 12-bit rgb, frame-synchronous snapshot
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_board_renderer
  import vga_board_renderer_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        bright,
  input  logic [63:0] board_flat,
  input  logic [3:0]  new_tile_idx,
  input  logic        new_tile_vld,
  input  logic        win,
  input  logic        lose,
  input  logic        board_valid,
  output logic        board_ack,
  output logic        frame_start,
  output logic [11:0] rgb
);

  logic        frame_cmp_q, frame_cmp_d;
  logic        snap_cmp_q, snap_cmp_d;
  logic        frame_start_q, frame_start_d;
  logic        board_ack_q, board_ack_d;
  logic [63:0] board_q, board_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic [3:0]  flash_idx_q, flash_idx_d;
  logic [5:0]  flash_cnt_q, flash_cnt_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;
  pix_class_e  cls_q, cls_d;
  logic [3:0]  tidx_q, tidx_d;
  logic        bright_s1_q, bright_s1_d;
  logic [11:0] rgb_q, rgb_d;

  logic               frame_evt, snap_evt, capture, flash_hit;
  logic signed [10:0] rx, ry;
  axis_pos_t          ax, ay;
  logic [3:0]         tile_exp;
  logic [11:0]        lut_rgb;

  tile_color_lut u_lut (
    .tile_exp (tile_exp),
    .color    (lut_rgb)
  );

  always_comb begin
    // Counts dwell for several clocks, so events are edges of the compares.
    frame_cmp_d = (hCount == 10'd0) && (vCount == 10'd0);
    snap_cmp_d  = (hCount == 10'd0) && (vCount == SNAP_LINE);
    frame_evt   = frame_cmp_d && !frame_cmp_q;
    snap_evt    = snap_cmp_d && !snap_cmp_q;
    capture     = snap_evt && board_valid;

    frame_start_d = frame_evt;
    board_ack_d   = capture;
    board_d       = capture ? board_flat : board_q;
    win_d         = capture ? win : win_q;
    lose_d        = capture ? lose : lose_q;
    flash_idx_d   = flash_idx_q;
    flash_cnt_d   = flash_cnt_q;
    if (capture && new_tile_vld) begin
      flash_idx_d = new_tile_idx;
      flash_cnt_d = FLASH_FRM;
    end else if (frame_evt && (flash_cnt_q != 6'd0)) begin
      flash_cnt_d = flash_cnt_q - 6'd1;
    end
    frame_cnt_d = frame_cnt_q + {2'b00, frame_evt};

    rx = $signed({1'b0, hCount}) - BOARD_X0;
    ry = $signed({1'b0, vCount}) - BOARD_Y0;
    ax = locate_axis(rx);
    ay = locate_axis(ry);
    if (ax.outside || ay.outside) begin
      cls_d = PIX_OUTSIDE;
    end else if (ax.on_tile && ay.on_tile) begin
      cls_d = PIX_TILE;
    end else begin
      cls_d = PIX_GRID;
    end
    tidx_d      = {ay.idx, ax.idx};
    bright_s1_d = bright;

    tile_exp  = board_q[{tidx_q, 2'b00} +: 4];
    flash_hit = (flash_cnt_q != 6'd0) && (tidx_q == flash_idx_q) && frame_cnt_q[2];
    rgb_d     = 12'h000;
    if (bright_s1_q) begin
      case (cls_q)
        PIX_OUTSIDE: rgb_d = win_q ? WIN_BG : (lose_q ? LOSE_BG : BG);
        PIX_GRID:    rgb_d = GRID_C;
        PIX_TILE:    rgb_d = flash_hit ? FLASH_C : lut_rgb;
        default:     rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cmp_q   <= 1'b0;
      snap_cmp_q    <= 1'b0;
      frame_start_q <= 1'b0;
      board_ack_q   <= 1'b0;
      board_q       <= 64'd0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      flash_idx_q   <= 4'd0;
      flash_cnt_q   <= 6'd0;
      frame_cnt_q   <= 3'd0;
      cls_q         <= PIX_OUTSIDE;
      tidx_q        <= 4'd0;
      bright_s1_q   <= 1'b0;
      rgb_q         <= 12'h000;
    end else begin
      frame_cmp_q   <= frame_cmp_d;
      snap_cmp_q    <= snap_cmp_d;
      frame_start_q <= frame_start_d;
      board_ack_q   <= board_ack_d;
      board_q       <= board_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      flash_idx_q   <= flash_idx_d;
      flash_cnt_q   <= flash_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      cls_q         <= cls_d;
      tidx_q        <= tidx_d;
      bright_s1_q   <= bright_s1_d;
      rgb_q         <= rgb_d;
    end
  end

  assign board_ack   = board_ack_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_board_renderer.sv
// ============================================================================
// tb_vga_board_renderer : directed vectors for vga_board_renderer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_board_renderer;
  import vga_board_renderer_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  hCount, vCount;
  logic        bright;
  logic [63:0] board_flat;
  logic [3:0]  new_tile_idx;
  logic        new_tile_vld, win, lose, board_valid;
  logic        board_ack, frame_start;
  logic [11:0] rgb;

  always #5 Clk = ~Clk;

  vga_board_renderer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hCount       (hCount),
    .vCount       (vCount),
    .bright       (bright),
    .board_flat   (board_flat),
    .new_tile_idx (new_tile_idx),
    .new_tile_vld (new_tile_vld),
    .win          (win),
    .lose         (lose),
    .board_valid  (board_valid),
    .board_ack    (board_ack),
    .frame_start  (frame_start),
    .rgb          (rgb)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        b;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [19];

  int n_vec = 0;
  int n_err = 0;
  int ack_total = 0;
  int fs_total = 0;
  int m_frame = 0;
  int m_flash = 0;
  int m_fidx = 0;

  localparam logic [63:0] BOARD_B3 = 64'h0000_0B00_00E0_2301;

  always @(posedge Clk) begin
    #1;
    if (board_ack) ack_total++;
    if (frame_start) fs_total++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_pix(input int h, input int v, input logic b);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
  endtask

  task automatic pix(input int h, input int v, input logic b);
    set_pix(h, v, b);
    tick(4);
  endtask

  task automatic probe(input string name, input int h, input int v, input logic b,
                       input logic [11:0] exp);
    set_pix(h, v, b);
    tick(2);
    check(name, {20'd0, rgb}, {20'd0, exp});
    tick(2);
  endtask

  task automatic frame_begin();
    int fs0 = fs_total;
    pix(0, 0, 1'b0);
    pix(1, 0, 1'b0);
    check("frame_start_count", fs_total - fs0, 1);
    m_frame = (m_frame + 1) % 8;
    if (m_flash > 0) m_flash--;
  endtask

  task automatic frame_end(input int exp_ack);
    int a0 = ack_total;
    if (board_valid && new_tile_vld) begin
      m_flash = 32;
      m_fidx  = int'(new_tile_idx);
    end
    pix(0, 520, 1'b0);
    pix(1, 520, 1'b0);
    check("board_ack_count", ack_total - a0, exp_ack);
  endtask

  initial begin
    vecs[0]  = '{10'd394, 10'd205, 1'b1, TILE_C11};
    vecs[1]  = '{10'd394, 10'd205, 1'b0, 12'h000};
    vecs[2]  = '{10'd494, 10'd305, 1'b1, TILE_C11};
    vecs[3]  = '{10'd260, 10'd70,  1'b1, TILE_C1};
    vecs[4]  = '{10'd251, 10'd70,  1'b1, GRID_C};
    vecs[5]  = '{10'd252, 10'd70,  1'b1, TILE_C1};
    vecs[6]  = '{10'd351, 10'd70,  1'b1, TILE_C1};
    vecs[7]  = '{10'd352, 10'd70,  1'b1, GRID_C};
    vecs[8]  = '{10'd243, 10'd70,  1'b1, BG};
    vecs[9]  = '{10'd683, 10'd70,  1'b1, GRID_C};
    vecs[10] = '{10'd684, 10'd70,  1'b1, BG};
    vecs[11] = '{10'd260, 10'd494, 1'b1, GRID_C};
    vecs[12] = '{10'd260, 10'd495, 1'b1, BG};
    vecs[13] = '{10'd474, 10'd70,  1'b1, TILE_C3};
    vecs[14] = '{10'd624, 10'd70,  1'b1, TILE_C2};
    vecs[15] = '{10'd300, 10'd200, 1'b1, EMPTY_C};
    vecs[16] = '{10'd150, 10'd40,  1'b1, BG};
    vecs[17] = '{10'd260, 10'd62,  1'b1, GRID_C};
    vecs[18] = '{10'd260, 10'd63,  1'b1, TILE_C1};

    Reset = 1'b1;
    set_pix(300, 100, 1'b1);
    board_flat = 64'd0; new_tile_idx = 4'd0; new_tile_vld = 1'b0;
    win = 1'b0; lose = 1'b0; board_valid = 1'b0;
    tick(3);
    check("reset_rgb", {20'd0, rgb}, 32'h0);
    check("reset_ack", {31'd0, board_ack}, 32'd0);
    check("reset_frame_start", {31'd0, frame_start}, 32'd0);
    Reset = 1'b0;
    tick(4);
    check("pre_midreset_rgb", {20'd0, rgb}, {20'd0, EMPTY_C});

    // Reset held three cycles mid-frame, then the pipeline refills
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("midreset_rgb", {20'd0, rgb}, 32'h0);
      check("midreset_ack", {31'd0, board_ack}, 32'd0);
    end
    Reset = 1'b0;
    m_frame = 0; m_flash = 0;
    tick(1);
    check("refill_1clk_rgb", {20'd0, rgb}, 32'h0);
    tick(1);
    check("refill_2clk_rgb", {20'd0, rgb}, {20'd0, EMPTY_C});
    tick(2);
    probe("grid_244_55", 244, 55, 1'b1, GRID_C);
    probe("empty_300_100", 300, 100, 1'b1, EMPTY_C);

    // Single tile capture and per-frame recapture
    board_flat = 64'h1; board_valid = 1'b1;
    frame_begin();
    probe("tile0_before_capture", 260, 70, 1'b1, EMPTY_C);
    frame_end(1);
    frame_begin();
    probe("tile0_after_capture", 260, 70, 1'b1, TILE_C1);
    frame_end(1);
    board_valid = 1'b0;
    frame_begin();
    frame_end(0);

    // Table of pixel classifications against board B3
    board_flat = BOARD_B3; board_valid = 1'b1;
    frame_begin();
    frame_end(1);
    board_valid = 1'b0;
    frame_begin();
    for (int i = 0; i < 19; i++) begin
      set_pix(int'(vecs[i].h), int'(vecs[i].v), vecs[i].b);
      tick(2);
      check($sformatf("vec%0d_rgb", i), {20'd0, rgb}, {20'd0, vecs[i].exp_rgb});
      tick(2);
    end

    // Two-clock latency from counts to rgb
    pix(394, 205, 1'b1);
    set_pix(300, 200, 1'b1);
    tick(1);
    check("latency_1clk_old", {20'd0, rgb}, {20'd0, TILE_C11});
    tick(1);
    check("latency_2clk_new", {20'd0, rgb}, {20'd0, EMPTY_C});
    tick(2);
    set_pix(300, 200, 1'b0);
    tick(1);
    check("blank_1clk_old", {20'd0, rgb}, {20'd0, EMPTY_C});
    tick(1);
    check("blank_2clk_black", {20'd0, rgb}, 32'h0);
    tick(2);
    frame_end(0);

    // New tile flash on tile 3, restarted at frame 10, untouched by a vld=0 capture
    board_valid = 1'b1; new_tile_idx = 4'd3; new_tile_vld = 1'b1;
    frame_begin();
    frame_end(1);
    board_valid = 1'b0;
    for (int f = 1; f <= 44; f++) begin
      frame_begin();
      probe($sformatf("flash_f%0d_tile3", f), 624, 70, 1'b1,
            ((m_flash != 0) && (m_fidx == 3) && m_frame[2]) ? FLASH_C : TILE_C2);
      probe($sformatf("flash_f%0d_tile0", f), 260, 70, 1'b1, TILE_C1);
      if (f == 10) begin
        board_valid = 1'b1;
        frame_end(1);
        board_valid = 1'b0;
      end else if (f == 20) begin
        board_valid = 1'b1; new_tile_vld = 1'b0;
        frame_end(1);
        board_valid = 1'b0;
      end else begin
        frame_end(0);
      end
    end

    // Background colour from win/lose flags
    board_valid = 1'b1; win = 1'b1; lose = 1'b1;
    frame_begin();
    frame_end(1);
    win = 1'b0;
    frame_begin();
    probe("win_bg", 150, 40, 1'b1, WIN_BG);
    frame_end(1);
    lose = 1'b0;
    frame_begin();
    probe("lose_bg", 150, 40, 1'b1, LOSE_BG);
    frame_end(1);
    board_valid = 1'b0;
    frame_begin();
    probe("plain_bg", 150, 40, 1'b1, BG);
    frame_end(0);

    // board_valid withdrawn before the snapshot line
    board_flat = 64'h5; board_valid = 1'b1;
    frame_begin();
    probe("withdrawn_before", 260, 70, 1'b1, TILE_C1);
    board_valid = 1'b0;
    frame_end(0);
    frame_begin();
    probe("withdrawn_after", 260, 70, 1'b1, TILE_C1);
    frame_end(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
